// File: rtl/mcu_port_pkg.sv
// Shared constants, line-format encodings and state type for the MCU sysctrl port blocks.
// bit_div() rounds CLK_HZ/BAUD to the nearest integer clock count per bit.
package mcu_port_pkg;

  localparam logic [7:0] PORT_TYPE_SERIAL = 8'd0;

  localparam logic [1:0] FMT_STOP_1      = 2'd1;
  localparam logic [1:0] FMT_PARITY_NONE = 2'd0;
  localparam logic [3:0] FMT_DATABITS_8  = 4'd8;
  localparam logic [7:0] FMT_FLOW_CTRL   = 8'h80;

  typedef struct packed {
    logic [1:0] stopbits;
    logic [1:0] parity;
    logic [3:0] databits;
  } line_fmt_t;

  localparam line_fmt_t LINE_FMT_8N1 = '{
    stopbits: FMT_STOP_1,
    parity:   FMT_PARITY_NONE,
    databits: FMT_DATABITS_8
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_RECOVER
  } uart_state_e;

  function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/port_sync_fifo.sv
// Show-ahead synchronous FIFO with fill level; rdata_o is registered and holds when empty.
// Pointers carry one extra MSB so full and empty are distinguishable.
module port_sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   level_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] rdata_q;
  logic         empty_c, full_c, push_ok_c, pop_ok_c;

  assign level_o = wptr_q - rptr_q;
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = rdata_q;

  always_comb begin
    push_ok_c = push_i & ~full_c;
    pop_ok_c  = pop_i & ~empty_c;
    wptr_d    = wptr_q + (AW+1)'(push_ok_c);
    rptr_d    = rptr_q + (AW+1)'(pop_ok_c);
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  // Head register forwards the incoming byte when it lands in the head slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (wptr_d != rptr_d)
        rdata_q <= (rptr_d == wptr_q) ? wdata_i : mem_q[rptr_d[AW-1:0]];
    end
  end

endmodule

// File: rtl/mcu_uart_port.sv
// Serial (type 0) sysctrl port: 8N1 UART tunnelled through rx/tx FIFOs.
// Define UART_PORT_FLOW_CTRL_EN to add uart_cts_n/uart_rts_n hardware flow control.
module mcu_uart_port
  import mcu_port_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 31_500_000,
  parameter int unsigned BAUD    = 115_200,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        uart_txd,
`ifdef UART_PORT_FLOW_CTRL_EN
  input  logic        uart_cts_n,
  output logic        uart_rts_n,
`endif
  output logic [31:0] port_status,
  output logic [7:0]  port_out_available,
  input  logic        port_out_strobe,
  output logic [7:0]  port_out_data,
  output logic [7:0]  port_in_available,
  input  logic        port_in_strobe,
  input  logic [7:0]  port_in_data,
  output logic        rx_overflow,
  output logic        rx_frame_err,
  input  logic        err_clear
);

  localparam int unsigned BIT_DIV  = bit_div(CLK_HZ, BAUD);
  localparam int unsigned HALF_DIV = BIT_DIV / 2;
  localparam int unsigned DEPTH    = 1 << FIFO_AW;
  localparam int unsigned CW       = $clog2(BIT_DIV + 1);
`ifdef UART_PORT_FLOW_CTRL_EN
  localparam logic [7:0]  FMT      = 8'(LINE_FMT_8N1) | FMT_FLOW_CTRL;
`else
  localparam logic [7:0]  FMT      = 8'(LINE_FMT_8N1);
`endif

  logic [FIFO_AW:0] rx_level, tx_level;
  logic [8:0]       rx_lvl9, tx_free9;
  logic [7:0]       tx_head;
  logic             rx_full_c, tx_empty_c, cts_ok_c;

  assign port_status = {8'(BAUD), 8'(BAUD >> 8), 8'(BAUD >> 16), FMT};

  assign rx_full_c          = (rx_level == (FIFO_AW+1)'(DEPTH));
  assign tx_empty_c         = (tx_level == '0);
  assign rx_lvl9            = 9'(rx_level);
  assign tx_free9           = 9'(DEPTH) - 9'(tx_level);
  assign port_out_available = rx_lvl9[8] ? 8'hFF : rx_lvl9[7:0];
  assign port_in_available  = tx_free9[8] ? 8'hFF : tx_free9[7:0];

  // Input synchroniser plus one delayed copy for falling-edge detection.
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q, rx_fall_c;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end
  assign rx_fall_c = rxd_prev_q & ~rxd_sync_q;

`ifdef UART_PORT_FLOW_CTRL_EN
  logic cts_meta_q, cts_sync_q, rts_n_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
      rts_n_q    <= 1'b0;
    end else begin
      cts_meta_q <= uart_cts_n;
      cts_sync_q <= cts_meta_q;
      rts_n_q    <= (rx_level >= (FIFO_AW+1)'(DEPTH - 2));
    end
  end
  assign cts_ok_c   = ~cts_sync_q;
  assign uart_rts_n = rts_n_q;
`else
  assign cts_ok_c = 1'b1;
`endif

  // ---------------- RX deserialiser ----------------
  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_push_q, rx_ovf_q, rx_ferr_q;
  logic          rx_tick_c, rx_sample_c, rx_done_c, rx_bad_c, rx_cnt_clr_c;

  assign rx_tick_c = (rx_state_q == ST_START) ? (rx_cnt_q == CW'(HALF_DIV - 1))
                                              : (rx_cnt_q == CW'(BIT_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state_q <= ST_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      ST_IDLE:    if (rx_fall_c) rx_state_d = ST_START;
      ST_START:   if (rx_tick_c) rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
      ST_DATA:    if (rx_tick_c && rx_bit_q == 3'd7) rx_state_d = ST_STOP;
      ST_STOP:    if (rx_tick_c) rx_state_d = rxd_sync_q ? ST_IDLE : ST_RECOVER;
      ST_RECOVER: if (rxd_sync_q) rx_state_d = ST_IDLE;
      default:    rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_clr_c = 1'b1;
    rx_sample_c  = 1'b0;
    rx_done_c    = 1'b0;
    rx_bad_c     = 1'b0;
    case (rx_state_q)
      ST_START: rx_cnt_clr_c = rx_tick_c;
      ST_DATA: begin
        rx_cnt_clr_c = rx_tick_c;
        rx_sample_c  = rx_tick_c;
      end
      ST_STOP: begin
        rx_cnt_clr_c = rx_tick_c;
        rx_done_c    = rx_tick_c & rxd_sync_q;
        rx_bad_c     = rx_tick_c & ~rxd_sync_q;
      end
      default: ;
    endcase
  end

  // Sticky flags: a new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_push_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_cnt_q <= rx_cnt_clr_c ? '0 : rx_cnt_q + CW'(1);
      if (rx_sample_c) begin
        rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
        rx_bit_q   <= rx_bit_q + 3'd1;
      end
      rx_push_q <= rx_done_c & ~rx_full_c;
      rx_ovf_q  <= (rx_done_c & rx_full_c) | (rx_ovf_q & ~err_clear);
      rx_ferr_q <= rx_bad_c | (rx_ferr_q & ~err_clear);
    end
  end

  assign rx_overflow  = rx_ovf_q;
  assign rx_frame_err = rx_ferr_q;

  port_sync_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push_q),
    .wdata_i (rx_shift_q),
    .pop_i   (port_out_strobe),
    .rdata_o (port_out_data),
    .level_o (rx_level)
  );

  // ---------------- TX serialiser ----------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          txd_q, txd_d;
  logic          tx_tick_c, tx_go_c, tx_pop_c, tx_cnt_clr_c;

  assign tx_tick_c = (tx_cnt_q == CW'(BIT_DIV - 1));
  assign tx_go_c   = ~tx_empty_c & cts_ok_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state_q <= ST_IDLE;
    else       tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      ST_IDLE:  if (tx_go_c) tx_state_d = ST_START;
      ST_START: if (tx_tick_c) tx_state_d = ST_DATA;
      ST_DATA:  if (tx_tick_c && tx_bit_q == 3'd7) tx_state_d = ST_STOP;
      ST_STOP:  if (tx_tick_c) tx_state_d = tx_go_c ? ST_START : ST_IDLE;
      default:  tx_state_d = ST_IDLE;
    endcase
  end

  // A pop at the end of a stop bit chains straight into the next start bit.
  always_comb begin
    tx_pop_c     = 1'b0;
    tx_cnt_clr_c = tx_tick_c;
    tx_bit_d     = '0;
    tx_byte_d    = tx_byte_q;
    txd_d        = 1'b1;
    case (tx_state_q)
      ST_IDLE: begin
        tx_pop_c     = tx_go_c;
        tx_cnt_clr_c = 1'b1;
      end
      ST_DATA: tx_bit_d = tx_tick_c ? tx_bit_q + 3'd1 : tx_bit_q;
      ST_STOP: tx_pop_c = tx_tick_c & tx_go_c;
      default: ;
    endcase
    if (tx_pop_c) tx_byte_d = tx_head;
    case (tx_state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = tx_byte_d[tx_bit_d];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      tx_cnt_q  <= tx_cnt_clr_c ? '0 : tx_cnt_q + CW'(1);
      tx_bit_q  <= tx_bit_d;
      tx_byte_q <= tx_byte_d;
      txd_q     <= txd_d;
    end
  end

  assign uart_txd = txd_q;

  port_sync_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (port_in_strobe),
    .wdata_i (port_in_data),
    .pop_i   (tx_pop_c),
    .rdata_o (tx_head),
    .level_o (tx_level)
  );

endmodule
